parser_head_gen: RTL and testbench

Ingress head generator that sits directly upstream of the parser pipeline's layer-0 input (`i_head`/`i_meta`). It accepts a packet stream of 128-bit beats with a valid/ready handshake. It packs the first `HEAD_SLICE_MAX` × 64 bytes of each packet into tagged 512-bit head slices and emits one metadata slice per packet alongside the first head slice. Beats beyond the head window are accepted and discarded.

---
 rtl/parser_head_gen.sv | 211 +++++++++++++++++++++
 tb/tb_parser_head_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/parser_head_gen.sv
// parser_head_gen: packs the first HEAD_SLICE_MAX x 64 bytes of each ingress packet into
// tagged head slices plus one meta slice per packet. Optional macro: PARSER_HEAD_GEN_RUNT_DROP_EN.
package parser_pkg;
  localparam int TAG_VALID_BIT    = 0;
  localparam int TAG_SHIFT_BIT    = 1;
  localparam int TAG_TAIL_BIT     = 2;
  localparam int TAG_START_BIT    = 3;
  localparam int TAG_OFFSET_LSB   = 4;
  localparam int TAG_OFFSET_WIDTH = 6;
  localparam int TAG_WIDTH        = TAG_OFFSET_LSB + TAG_OFFSET_WIDTH;
endpackage

module parser_head_gen #(
  parameter int HEAD_WIDTH     = 512,
  parameter int META_WIDTH     = 512,
  parameter int TAG_WIDTH      = parser_pkg::TAG_WIDTH,
  parameter int BEAT_WIDTH     = 128,
  parameter int HEAD_SLICE_MAX = 2,
  parameter int PORT_WIDTH     = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [BEAT_WIDTH-1:0]           i_data,
  input  logic [BEAT_WIDTH/8-1:0]         i_keep,
  input  logic                            i_valid,
  input  logic                            i_last,
  input  logic [PORT_WIDTH-1:0]           i_port,
  output logic                            o_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);

  localparam int KEEP_W  = BEAT_WIDTH / 8;
  localparam int BEATS   = HEAD_WIDTH / BEAT_WIDTH;
  localparam int BIDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W = (HEAD_SLICE_MAX > 1) ? $clog2(HEAD_SLICE_MAX) : 1;
  localparam int OFF_W   = parser_pkg::TAG_OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HEAD = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BIDX_W-1:0]       r_beat_idx;
  logic [SLICE_W-1:0]      r_slice_idx;
  logic [6:0]              r_count;
  logic [HEAD_WIDTH-1:0]   r_acc;
  logic [PORT_WIDTH-1:0]   r_port;
  logic [15:0]             r_seq;
  logic                    r_ready;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] r_head;
  logic [META_WIDTH+TAG_WIDTH-1:0] r_meta;

  logic                    w_accept;
  logic                    w_packing;
  logic                    w_slice_done;
  logic                    w_last_slice;
  logic                    w_runt_drop;
  logic                    w_emit_head;
  logic                    w_emit_meta;
  logic [BEAT_WIDTH-1:0]   w_beat_masked;
  logic [HEAD_WIDTH-1:0]   w_acc_next;
  logic [6:0]              w_count_next;
  logic [PORT_WIDTH-1:0]   w_port_cur;
  logic [TAG_WIDTH-1:0]    w_head_tag;
  logic [TAG_WIDTH-1:0]    w_meta_tag;
  logic [META_WIDTH-1:0]   w_meta_data;

  function automatic logic [6:0] popcount(input logic [KEEP_W-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int k = 0; k < KEEP_W; k++) begin
      c = c + {6'd0, v[k]};
    end
    return c;
  endfunction

  assign w_accept     = i_valid & r_ready;
  assign w_packing    = w_accept & ((r_state == S_IDLE) | (r_state == S_HEAD));
  assign w_slice_done = w_packing & ((r_beat_idx == BIDX_W'(BEATS - 1)) | i_last);
  assign w_last_slice = (r_slice_idx == SLICE_W'(HEAD_SLICE_MAX - 1));
  assign w_count_next = r_count + popcount(i_keep);
  assign w_port_cur   = (r_state == S_IDLE) ? i_port : r_port;

`ifdef PARSER_HEAD_GEN_RUNT_DROP_EN
  // A packet that ends inside slice 0 below the minimum frame size never reaches the parser.
  assign w_runt_drop = w_packing & i_last & (r_slice_idx == SLICE_W'(0)) & (w_count_next < 7'd60);
`else
  assign w_runt_drop = 1'b0;
`endif

  // Byte enables are MSB-first: i_keep[KEEP_W-1] qualifies wire byte 0.
  always_comb begin
    w_beat_masked = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      if (i_keep[KEEP_W-1-j]) begin
        w_beat_masked[BEAT_WIDTH-1-8*j -: 8] = i_data[BEAT_WIDTH-1-8*j -: 8];
      end else begin
        w_beat_masked[BEAT_WIDTH-1-8*j -: 8] = 8'd0;
      end
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat_idx == BIDX_W'(k)) begin
        w_acc_next[HEAD_WIDTH-1-BEAT_WIDTH*k -: BEAT_WIDTH] = w_beat_masked;
      end else begin
        w_acc_next[HEAD_WIDTH-1-BEAT_WIDTH*k -: BEAT_WIDTH] = r_acc[HEAD_WIDTH-1-BEAT_WIDTH*k -: BEAT_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HEAD: begin
        if (!w_accept) begin
          w_state_next = r_state;
        end else if (i_last) begin
          w_state_next = S_IDLE;
        end else if (w_slice_done && w_last_slice) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_HEAD;
        end
      end
      S_DRAIN: begin
        if (w_accept && i_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_emit_head = w_slice_done & ~w_runt_drop;
    w_emit_meta = w_emit_head & (r_slice_idx == SLICE_W'(0));
    w_head_tag  = '0;
    w_head_tag[parser_pkg::TAG_VALID_BIT] = 1'b1;
    w_head_tag[parser_pkg::TAG_SHIFT_BIT] = 1'b0;
    w_head_tag[parser_pkg::TAG_TAIL_BIT]  = i_last | w_last_slice;
    w_head_tag[parser_pkg::TAG_START_BIT] = (r_slice_idx == SLICE_W'(0));
    w_head_tag[parser_pkg::TAG_OFFSET_LSB +: OFF_W] = w_count_next[OFF_W-1:0] - OFF_W'(1);
    w_meta_tag  = '0;
    w_meta_tag[parser_pkg::TAG_VALID_BIT] = 1'b1;
    w_meta_tag[parser_pkg::TAG_TAIL_BIT]  = 1'b1;
    w_meta_tag[parser_pkg::TAG_START_BIT] = 1'b1;
    w_meta_tag[parser_pkg::TAG_OFFSET_LSB +: OFF_W] = '1;
    w_meta_data = '0;
    w_meta_data[META_WIDTH-1 -: 16]          = r_seq;
    w_meta_data[META_WIDTH-17 -: PORT_WIDTH] = w_port_cur;
  end

  // The accumulator clears on every completed slice so the next slice starts zero-filled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_beat_idx  <= '0;
      r_slice_idx <= '0;
      r_count     <= 7'd0;
      r_port      <= '0;
      r_seq       <= 16'd0;
      r_ready     <= 1'b0;
      r_head      <= '0;
      r_meta      <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_slice_done) begin
        r_acc       <= '0;
        r_beat_idx  <= '0;
        r_count     <= 7'd0;
        r_slice_idx <= (i_last || w_last_slice) ? SLICE_W'(0) : r_slice_idx + SLICE_W'(1);
      end else if (w_packing) begin
        r_acc       <= w_acc_next;
        r_beat_idx  <= r_beat_idx + BIDX_W'(1);
        r_count     <= w_count_next;
      end else begin
        r_acc       <= r_acc;
      end
      if (w_accept && (r_state == S_IDLE)) begin
        r_port <= i_port;
      end else begin
        r_port <= r_port;
      end
      if (w_emit_meta) begin
        r_seq <= r_seq + 16'd1;
      end else begin
        r_seq <= r_seq;
      end
      r_head <= w_emit_head ? {w_head_tag, w_acc_next} : '0;
      r_meta <= w_emit_meta ? {w_meta_tag, w_meta_data} : '0;
    end
  end

  assign o_ready = r_ready;
  assign o_head  = r_head;
  assign o_meta  = r_meta;

endmodule

// File: tb/tb_parser_head_gen.sv
// Directed bench for parser_head_gen: hand-built packets, expected slices rebuilt from a byte pattern.
`timescale 1ns/1ps
module tb_parser_head_gen;
  localparam int HW = 512;
  localparam int MW = 512;
  localparam int TW = parser_pkg::TAG_WIDTH;
  localparam int SMAX = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [127:0]      i_data = '0;
  logic [15:0]       i_keep = '0;
  logic              i_valid = 1'b0;
  logic              i_last = 1'b0;
  logic [3:0]        i_port = '0;
  logic              o_ready;
  logic [HW+TW-1:0]  o_head;
  logic [MW+TW-1:0]  o_meta;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] seq_model = 16'd0;

  parser_head_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_keep(i_keep),
    .i_valid(i_valid), .i_last(i_last), .i_port(i_port),
    .o_ready(o_ready), .o_head(o_head), .o_meta(o_meta)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] pbyte(input int seed, input int n);
    return 8'((n * 7 + seed * 31) & 255);
  endfunction

  function automatic logic [HW+TW-1:0] exp_head(input int seed, input int slice, input int nb,
                                                 input bit start, input bit tail);
    logic [HW-1:0] d;
    logic [TW-1:0] t;
    d = '0;
    for (int i = 0; i < nb; i++) d[HW-1-8*i -: 8] = pbyte(seed, slice * 64 + i);
    t = '0;
    t[parser_pkg::TAG_VALID_BIT] = 1'b1;
    t[parser_pkg::TAG_START_BIT] = start;
    t[parser_pkg::TAG_TAIL_BIT]  = tail;
    t[parser_pkg::TAG_OFFSET_LSB +: 6] = 6'(nb - 1);
    return {t, d};
  endfunction

  function automatic logic [MW+TW-1:0] exp_meta(input logic [15:0] seq, input logic [3:0] port);
    logic [MW-1:0] d;
    logic [TW-1:0] t;
    d = '0;
    d[511 -: 16] = seq;
    d[495 -: 4]  = port;
    t = '0;
    t[parser_pkg::TAG_VALID_BIT] = 1'b1;
    t[parser_pkg::TAG_START_BIT] = 1'b1;
    t[parser_pkg::TAG_TAIL_BIT]  = 1'b1;
    t[parser_pkg::TAG_OFFSET_LSB +: 6] = 6'd63;
    return {t, d};
  endfunction

  task automatic chk(input string tag, input logic [HW+TW-1:0] obs, input logic [HW+TW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  // Drives one packet beat by beat and checks both outputs after every accepting edge.
  task automatic send_pkt(input string name, input int nbytes, input int seed, input logic [3:0] port,
                          input int gap_after, input bit drop);
    int nbeats, rem, slice, nb;
    bit last, done;
    logic [15:0]  k;
    logic [127:0] d;
    logic [HW+TW-1:0] eh;
    logic [MW+TW-1:0] em;
    nbeats = (nbytes + 15) / 16;
    for (int b = 0; b < nbeats; b++) begin
      rem  = nbytes - b * 16;
      k    = (rem >= 16) ? 16'hFFFF : (16'hFFFF << (16 - rem));
      for (int j = 0; j < 16; j++) d[127-8*j -: 8] = pbyte(seed, b * 16 + j);
      last = (b == nbeats - 1);
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = d;
      i_keep  = k;
      i_last  = last;
      i_port  = (b == 0) ? port : ~port;
      @(posedge i_clk);
      #1;
      slice = b / 4;
      done  = (slice < SMAX) && ((b % 4 == 3) || last) && !drop;
      eh = '0;
      em = '0;
      if (done) begin
        nb = nbytes - slice * 64;
        if (nb > 64) nb = 64;
        eh = exp_head(seed, slice, nb, slice == 0, last || (slice == SMAX - 1));
        if (slice == 0) em = exp_meta(seq_model, port);
      end
      chk($sformatf("%s_head_b%0d", name, b), o_head, eh);
      chk($sformatf("%s_meta_b%0d", name, b), o_meta, em);
      chk($sformatf("%s_ready_b%0d", name, b), {{(HW+TW-1){1'b0}}, o_ready}, 1);
      if (b == gap_after) begin
        @(negedge i_clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(posedge i_clk);
        #1;
        chk($sformatf("%s_gap_head", name), o_head, '0);
        chk($sformatf("%s_gap_meta", name), o_meta, '0);
      end
    end
    if (!drop) seq_model = seq_model + 16'd1;
  endtask

  initial begin
    bit runt_drop;
`ifdef PARSER_HEAD_GEN_RUNT_DROP_EN
    runt_drop = 1'b1;
`else
    runt_drop = 1'b0;
`endif
    #2;
    chk("rst_head", o_head, '0);
    chk("rst_meta", o_meta, '0);
    chk("rst_ready", {{(HW+TW-1){1'b0}}, o_ready}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);
    chk("ready_after_rst", {{(HW+TW-1){1'b0}}, o_ready}, 1);

    send_pkt("p64", 64, 1, 4'd3, -1, 1'b0);
    idle(1);
    send_pkt("p200", 200, 2, 4'd5, 1, 1'b0);
    idle(1);
    send_pkt("p70", 70, 3, 4'd9, -1, 1'b0);
    idle(1);
    send_pkt("p40", 40, 4, 4'd1, -1, runt_drop);
    idle(1);
    send_pkt("b2b_a", 64, 5, 4'd2, -1, 1'b0);
    send_pkt("b2b_b", 64, 6, 4'd6, -1, 1'b0);
    idle(1);

    // Reset in the middle of a packet, then a fresh packet restarts at seq 0.
    for (int b = 0; b < 2; b++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_last  = 1'b0;
      i_keep  = 16'hFFFF;
      i_data  = {4{32'hA5A5_0000 + 32'(b)}};
      i_port  = 4'd7;
    end
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("midrst_head", o_head, '0);
    chk("midrst_meta", o_meta, '0);
    chk("midrst_ready", {{(HW+TW-1){1'b0}}, o_ready}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seq_model = 16'd0;
    idle(2);
    send_pkt("post_rst", 64, 7, 4'd11, -1, 1'b0);
    idle(1);

`ifndef PARSER_HEAD_GEN_RUNT_DROP_EN
    // Fast-forward the sequence counter with single-beat packets, then check the wrap.
    while (seq_model != 16'hFFFF) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_last  = 1'b1;
      i_keep  = 16'hFFFF;
      i_port  = 4'd0;
      @(posedge i_clk);
      seq_model = seq_model + 16'd1;
    end
    send_pkt("seq_ffff", 16, 8, 4'd12, -1, 1'b0);
    send_pkt("seq_wrap", 16, 9, 4'd13, -1, 1'b0);
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
